// File: rtl/dual_fetch_responder_pkg.sv
// Shared types and constants for the dual-core instruction fetch responder.
package fetch_pkg;
  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 32;
  localparam int NUM_PORTS = 2;
  localparam int CNT_W     = 4;   // enough for LATENCY up to 15

  localparam logic [DATA_W-1:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} port_state_t;

  // Response payload chosen at grant time and carried to the RESP cycle.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
  } fetch_rsp_t;
endpackage

// File: rtl/dual_fetch_responder_if.sv
// Bus bundle between the two cores / run controller and the responder.
interface dual_fetch_responder_if;
  import fetch_pkg::*;

  logic              prog_we_i;
  logic [ADDR_W-1:0] prog_addr_i;
  logic [DATA_W-1:0] prog_wdata_i;
  logic              enable_1_i, enable_2_i;
  logic              req_1_i, req_2_i;
  logic [ADDR_W-1:0] addr_1_i, addr_2_i;
  logic              gnt_1_o, gnt_2_o;
  logic              rvalid_1_o, rvalid_2_o;
  logic [DATA_W-1:0] rdata_1_o, rdata_2_o;
  logic              err_1_o, err_2_o;
  logic              fetch_1_o, fetch_2_o;
  logic [ADDR_W-1:0] instr_addr_1_o, instr_addr_2_o;

  // Responder side
  modport slave (
    input  prog_we_i, prog_addr_i, prog_wdata_i, enable_1_i, enable_2_i,
           req_1_i, req_2_i, addr_1_i, addr_2_i,
    output gnt_1_o, gnt_2_o, rvalid_1_o, rvalid_2_o, rdata_1_o, rdata_2_o,
           err_1_o, err_2_o, fetch_1_o, fetch_2_o, instr_addr_1_o, instr_addr_2_o
  );

  // Cores / run controller side
  modport master (
    output prog_we_i, prog_addr_i, prog_wdata_i, enable_1_i, enable_2_i,
           req_1_i, req_2_i, addr_1_i, addr_2_i,
    input  gnt_1_o, gnt_2_o, rvalid_1_o, rvalid_2_o, rdata_1_o, rdata_2_o,
           err_1_o, err_2_o, fetch_1_o, fetch_2_o, instr_addr_1_o, instr_addr_2_o
  );
endinterface

// File: rtl/dual_fetch_responder_port.sv
// One fetch port: IDLE/WAIT/RESP FSM, latency counter, capture registers
// and the one-cycle fetch strobe. Response data is selected by the parent
// at grant time and held here until the RESP cycle.
module fetch_port
  import fetch_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              enable_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  fetch_rsp_t        sel_i,
  output logic              gnt_o,
  output logic              rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  output logic              fetch_o,
  output logic [ADDR_W-1:0] instr_addr_o
);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  port_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  fetch_rsp_t        pend_q, pend_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] iaddr_q, iaddr_d;
  logic              fetch_q, fetch_d;

  // State and capture registers; image contents live in the parent.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      rdata_q <= '0;
      iaddr_q <= '0;
      fetch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      rdata_q <= rdata_d;
      iaddr_q <= iaddr_d;
      fetch_q <= fetch_d;
    end
  end

  // Next state; grant is combinational and gated by reset so outputs are 0 in reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    rdata_d = rdata_q;
    iaddr_d = iaddr_q;
    fetch_d = 1'b0;
    gnt_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_i && enable_i && rst_ni) begin
          gnt_o   = 1'b1;
          fetch_d = 1'b1;
          iaddr_d = addr_i;
          pend_d  = sel_i;
          cnt_d   = CNT_LOAD;
          if (LATENCY == 1) begin
            state_d = RESP;
            rdata_d = sel_i.data;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) begin
          state_d = RESP;
          rdata_d = pend_q.data;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rvalid_o     = (state_q == RESP);
  assign err_o        = rvalid_o && pend_q.err;
  assign rdata_o      = rdata_q;
  assign fetch_o      = fetch_q;
  assign instr_addr_o = iaddr_q;
endmodule

// File: rtl/dual_fetch_responder.sv
// Shared program image with one write port and two combinational read
// ports, each feeding an independent fetch port with identical latency.
module dual_fetch_responder
  import fetch_pkg::*;
#(
  parameter int                MEM_WORDS      = 256,
  parameter int                LATENCY        = 2,
  parameter logic [ADDR_W-1:0] MAX_INSTR_ADDR = 16'h03FC
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  dual_fetch_responder_if.slave  bus
);
  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  // Depth compared against a full word index so out-of-depth writes/reads never alias.
  localparam logic [ADDR_W-2:0] DEPTH = (ADDR_W-1)'(MEM_WORDS);

  logic [DATA_W-1:0] mem [MEM_WORDS];

  logic [NUM_PORTS-1:0]             req, en, gnt, rvalid, err, fetch;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] addr, iaddr;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rdata;

  logic [ADDR_W-3:0] pw_idx;
  logic              unused_prog_lsb;

  assign pw_idx          = bus.prog_addr_i[ADDR_W-1:2];
  assign unused_prog_lsb = ^bus.prog_addr_i[1:0];

  // Image write port; not reset so the program survives a core reset.
  always_ff @(posedge clk_i) begin
    if (bus.prog_we_i && ({1'b0, pw_idx} < DEPTH))
      mem[pw_idx[AW-1:0]] <= bus.prog_wdata_i;
  end

  assign req  = {bus.req_2_i, bus.req_1_i};
  assign en   = {bus.enable_2_i, bus.enable_1_i};
  assign addr = {bus.addr_2_i, bus.addr_1_i};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [ADDR_W-3:0] widx;
    fetch_rsp_t        sel;

    assign widx = addr[p][ADDR_W-1:2];

    // Classify the address and read the pre-write image word for this cycle.
    always_comb begin
      sel = '{data: NOP_INSTR, err: 1'b0};
      if (addr[p][1:0] != 2'b00)
        sel.err = 1'b1;
      else if (addr[p] <= MAX_INSTR_ADDR && ({1'b0, widx} < DEPTH))
        sel.data = mem[widx[AW-1:0]];
    end

    fetch_port #(.LATENCY(LATENCY)) u_port (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .req_i        (req[p]),
      .enable_i     (en[p]),
      .addr_i       (addr[p]),
      .sel_i        (sel),
      .gnt_o        (gnt[p]),
      .rvalid_o     (rvalid[p]),
      .rdata_o      (rdata[p]),
      .err_o        (err[p]),
      .fetch_o      (fetch[p]),
      .instr_addr_o (iaddr[p])
    );
  end

  assign bus.gnt_1_o        = gnt[0];
  assign bus.gnt_2_o        = gnt[1];
  assign bus.rvalid_1_o     = rvalid[0];
  assign bus.rvalid_2_o     = rvalid[1];
  assign bus.rdata_1_o      = rdata[0];
  assign bus.rdata_2_o      = rdata[1];
  assign bus.err_1_o        = err[0];
  assign bus.err_2_o        = err[1];
  assign bus.fetch_1_o      = fetch[0];
  assign bus.fetch_2_o      = fetch[1];
  assign bus.instr_addr_1_o = iaddr[0];
  assign bus.instr_addr_2_o = iaddr[1];
endmodule

// File: tb/tb_dual_fetch_responder.sv
// Bench: directed scenarios plus randomized traffic, checked every cycle
// against a cycle-scheduled model of the fetch responder.
module tb_dual_fetch_responder;
  import fetch_pkg::*;

  localparam int          LAT   = 2;
  localparam int          WORDS = 256;
  localparam logic [15:0] MAXA  = 16'h03FC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dual_fetch_responder_if bus();

  dual_fetch_responder #(.MEM_WORDS(WORDS), .LATENCY(LAT), .MAX_INSTR_ADDR(MAXA)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: per port, the cycle numbers at which each observable event is due.
  int          cyc = 0;
  int          free_at [2];
  int          fetch_at[2];
  int          resp_at [2];
  int          iaddr_at[2];
  logic [31:0] pend_data[2], last_rdata[2];
  logic        pend_err [2];
  logic [15:0] pend_iaddr[2], last_iaddr[2];
  logic [31:0] img [WORDS];

  function automatic logic [32:0] ref_fetch(input logic [15:0] a);
    if (a % 4 != 0)                            return {1'b1, NOP_INSTR};
    if (a > MAXA || int'(a) / 4 >= WORDS)      return {1'b0, NOP_INSTR};
    return {1'b0, img[int'(a) / 4]};
  endfunction

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    logic        r [2], e [2], g [2], rv [2], er [2], f [2], exp_g;
    logic [15:0] a [2], ia [2];
    logic [31:0] rd [2];
    r[0] = bus.req_1_i;      r[1] = bus.req_2_i;
    e[0] = bus.enable_1_i;   e[1] = bus.enable_2_i;
    a[0] = bus.addr_1_i;     a[1] = bus.addr_2_i;
    g[0] = bus.gnt_1_o;      g[1] = bus.gnt_2_o;
    rv[0] = bus.rvalid_1_o;  rv[1] = bus.rvalid_2_o;
    er[0] = bus.err_1_o;     er[1] = bus.err_2_o;
    f[0] = bus.fetch_1_o;    f[1] = bus.fetch_2_o;
    rd[0] = bus.rdata_1_o;   rd[1] = bus.rdata_2_o;
    ia[0] = bus.instr_addr_1_o; ia[1] = bus.instr_addr_2_o;
    for (int p = 0; p < 2; p++) begin
      if (!rst_n) begin
        free_at[p] = 0; fetch_at[p] = -1; resp_at[p] = -1; iaddr_at[p] = -1;
        last_rdata[p] = '0; last_iaddr[p] = '0;
        chk($sformatf("rst_gnt_%0d", p + 1), g[p], 0);
        chk($sformatf("rst_rvalid_%0d", p + 1), rv[p], 0);
        chk($sformatf("rst_err_%0d", p + 1), er[p], 0);
        chk($sformatf("rst_fetch_%0d", p + 1), f[p], 0);
        chk($sformatf("rst_rdata_%0d", p + 1), rd[p], 0);
        chk($sformatf("rst_iaddr_%0d", p + 1), ia[p], 0);
      end else begin
        exp_g = r[p] && e[p] && (cyc >= free_at[p]);
        if (cyc == iaddr_at[p]) last_iaddr[p] = pend_iaddr[p];
        if (cyc == resp_at[p])  last_rdata[p] = pend_data[p];
        chk($sformatf("gnt_%0d", p + 1), g[p], exp_g);
        chk($sformatf("fetch_%0d", p + 1), f[p], cyc == fetch_at[p]);
        chk($sformatf("rvalid_%0d", p + 1), rv[p], cyc == resp_at[p]);
        chk($sformatf("err_%0d", p + 1), er[p], (cyc == resp_at[p]) && pend_err[p]);
        chk($sformatf("rdata_%0d", p + 1), rd[p], last_rdata[p]);
        chk($sformatf("iaddr_%0d", p + 1), ia[p], last_iaddr[p]);
        if (exp_g) begin
          fetch_at[p] = cyc + 1;
          iaddr_at[p] = cyc + 1;
          resp_at[p]  = cyc + LAT;
          free_at[p]  = cyc + LAT + 1;
          pend_iaddr[p] = a[p];
          {pend_err[p], pend_data[p]} = ref_fetch(a[p]);
        end
      end
    end
    // Writes land at the coming edge, after this cycle's grant-time reads.
    if (bus.prog_we_i && int'(bus.prog_addr_i) / 4 < WORDS)
      img[int'(bus.prog_addr_i) / 4] = bus.prog_wdata_i;
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 9))
      7:       return 16'($urandom_range(0, 1023));
      8:       return 16'($urandom);
      9:       return 16'h0400 + 16'($urandom_range(0, 255));
      default: return 16'($urandom_range(0, WORDS - 1) * 4);
    endcase
  endfunction

  initial begin
    bus.prog_we_i = 0; bus.prog_addr_i = 0; bus.prog_wdata_i = 0;
    bus.enable_1_i = 0; bus.enable_2_i = 0;
    bus.req_1_i = 0; bus.req_2_i = 0; bus.addr_1_i = 0; bus.addr_2_i = 0;
    repeat (3) tick();
    rst_n = 1;
    bus.enable_1_i = 1; bus.enable_2_i = 1;

    // Load the image; word 0 and word 3 get known values.
    for (int i = 0; i < WORDS; i++) begin
      tick();
      bus.prog_we_i = 1; bus.prog_addr_i = 16'(i * 4);
      bus.prog_wdata_i = (i == 0) ? 32'hDEADBEEF : (i == 3) ? 32'h33333333 : $urandom;
    end
    tick(); bus.prog_addr_i = 16'h0400; bus.prog_wdata_i = 32'hBAD0BAD0;  // beyond depth
    tick(); bus.prog_we_i = 0;

    // Basic fetch of word 0 with LATENCY=2 (also shows the 0x400 write was dropped).
    tick(); bus.req_1_i = 1; bus.addr_1_i = 16'h0000;
    @(negedge clk); chk("t1_gnt", bus.gnt_1_o, 1);
    tick(); bus.req_1_i = 0;
    @(negedge clk); chk("t1_fetch", bus.fetch_1_o, 1); chk("t1_rvalid_early", bus.rvalid_1_o, 0);
    tick();
    @(negedge clk); chk("t1_rvalid", bus.rvalid_1_o, 1); chk("t1_rdata", bus.rdata_1_o, 32'hDEADBEEF);

    // Both ports, same address, same cycle.
    tick(); bus.req_1_i = 1; bus.req_2_i = 1; bus.addr_1_i = 16'h0004; bus.addr_2_i = 16'h0004;
    @(negedge clk); chk("t2_gnt", {bus.gnt_2_o, bus.gnt_1_o}, 2'b11);
    tick(); bus.req_1_i = 0; bus.req_2_i = 0;
    @(negedge clk); chk("t2_fetch", {bus.fetch_2_o, bus.fetch_1_o}, 2'b11);
    tick();
    @(negedge clk); chk("t2_rvalid", {bus.rvalid_2_o, bus.rvalid_1_o}, 2'b11);
    chk("t2_rdata_eq", bus.rdata_2_o, bus.rdata_1_o);

    // Misaligned above max, then aligned just above max.
    tick(); bus.req_2_i = 1; bus.addr_2_i = 16'h0402;
    tick(); bus.req_2_i = 0;
    tick();
    @(negedge clk); chk("t3_err_mis", bus.err_2_o, 1); chk("t3_rdata_mis", bus.rdata_2_o, NOP_INSTR);
    tick(); bus.req_2_i = 1; bus.addr_2_i = 16'h0400;
    tick(); bus.req_2_i = 0;
    tick();
    @(negedge clk); chk("t3_err_oor", bus.err_2_o, 0); chk("t3_rdata_oor", bus.rdata_2_o, NOP_INSTR);
    chk("t3_rvalid_oor", bus.rvalid_2_o, 1);

    // Enable drops after a grant: in-flight completes, new requests blocked.
    tick(); bus.req_1_i = 1; bus.addr_1_i = 16'h0008;
    tick(); bus.req_1_i = 0; bus.enable_1_i = 0;
    tick();
    @(negedge clk); chk("t4_rvalid", bus.rvalid_1_o, 1);
    for (int i = 0; i < 4; i++) begin
      tick(); bus.req_1_i = 1;
      @(negedge clk); chk("t4_no_gnt", bus.gnt_1_o, 0); chk("t4_no_fetch", bus.fetch_1_o, 0);
    end
    tick(); bus.req_1_i = 0; bus.enable_1_i = 1;

    // Write to word 3 in the grant cycle of a fetch of address 12.
    tick(); bus.req_1_i = 1; bus.addr_1_i = 16'h000C;
    bus.prog_we_i = 1; bus.prog_addr_i = 16'h000C; bus.prog_wdata_i = 32'hC0FFEE03;
    tick(); bus.req_1_i = 0; bus.prog_we_i = 0;
    tick();
    @(negedge clk); chk("t5_old", bus.rdata_1_o, 32'h33333333);
    tick(); bus.req_1_i = 1;
    tick(); bus.req_1_i = 0;
    tick();
    @(negedge clk); chk("t5_new", bus.rdata_1_o, 32'hC0FFEE03);

    // Reset in WAIT: outputs clear at once, no late response, image kept.
    tick(); bus.req_1_i = 1; bus.addr_1_i = 16'h0004;
    tick(); bus.req_1_i = 0; rst_n = 0;
    #1; chk("t6_fetch_rst", bus.fetch_1_o, 0); chk("t6_iaddr_rst", bus.instr_addr_1_o, 0);
    chk("t6_rdata_rst", bus.rdata_1_o, 0);
    tick(); rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("t6_no_rvalid", bus.rvalid_1_o, 0);
      tick();
    end
    bus.req_1_i = 1; bus.addr_1_i = 16'h0000;
    tick(); bus.req_1_i = 0;
    tick();
    @(negedge clk); chk("t6_img_kept", bus.rdata_1_o, 32'hDEADBEEF);

    // Randomized traffic, including rare resets and shared request streams.
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst_n = ($urandom_range(0, 399) != 0);
      bus.enable_1_i = ($urandom_range(0, 9) != 0);
      bus.enable_2_i = ($urandom_range(0, 9) != 0);
      bus.req_1_i = 1'($urandom_range(0, 1));
      bus.addr_1_i = rand_addr();
      if ($urandom_range(0, 3) == 0) begin
        bus.req_2_i = bus.req_1_i; bus.addr_2_i = bus.addr_1_i; bus.enable_2_i = bus.enable_1_i;
      end else begin
        bus.req_2_i = 1'($urandom_range(0, 1));
        bus.addr_2_i = rand_addr();
      end
      bus.prog_we_i = ($urandom_range(0, 9) == 0);
      bus.prog_addr_i = 16'($urandom_range(0, 319) * 4);
      bus.prog_wdata_i = $urandom;
    end
    tick();
    rst_n = 1; bus.req_1_i = 0; bus.req_2_i = 0; bus.prog_we_i = 0;
    repeat (6) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
